demux2_stream: RTL and testbench

- Registered 1-to-2 stream demultiplexer: the distributing end of the two-input selector path.
- Accepts one BUS_BITS-wide word per cycle on a valid/ready input and steers it to out1 or out2 according to sel.
- Each output has a one-entry holding register, so destinations can stall independently.
- Used to split a shared datapath result between two consumers, e.g. writeback vs. store path.

---
 rtl/demux2_stream_pkg.sv | 15 +
 rtl/demux2_stream_if.sv | 29 ++
 rtl/demux2_stream_slot.sv | 44 ++++
 rtl/demux2_stream.sv | 84 ++++++++
 tb/tb_demux2_stream.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/demux2_stream_pkg.sv
// rtl/demux2_stream_pkg.sv - shared defaults, select encodings and slot state type for demux2_stream
package demux2_stream_pkg;

   localparam int BUS_BITS_DEF = 64;
   localparam int CNT_BITS_DEF = 16;

   localparam logic SEL_OUT1 = 1'b0;
   localparam logic SEL_OUT2 = 1'b1;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

endpackage

// File: rtl/demux2_stream_if.sv
// rtl/demux2_stream_if.sv - input stream plus both output streams of demux2_stream
interface demux2_stream_if
   import demux2_stream_pkg::*;
#(
   parameter int BUS_BITS = BUS_BITS_DEF
);

   logic [BUS_BITS-1:0] in_data;
   logic                in_valid;
   logic                in_ready;
   logic                sel;
   logic [BUS_BITS-1:0] out1_data;
   logic                out1_valid;
   logic                out1_ready;
   logic [BUS_BITS-1:0] out2_data;
   logic                out2_valid;
   logic                out2_ready;

   modport master (
      output in_data, in_valid, sel, out1_ready, out2_ready,
      input  in_ready, out1_data, out1_valid, out2_data, out2_valid
   );

   modport slave (
      input  in_data, in_valid, sel, out1_ready, out2_ready,
      output in_ready, out1_data, out1_valid, out2_data, out2_valid
   );

endinterface

// File: rtl/demux2_stream_slot.sv
// rtl/demux2_stream_slot.sv - one-entry EMPTY/FULL holding register for one demux output
module stream_slot
   import demux2_stream_pkg::*;
#(
   parameter int BUS_BITS = BUS_BITS_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load_i,
   input  logic [BUS_BITS-1:0] data_i,
   input  logic                ready_i,
   output logic                valid_o,
   output logic [BUS_BITS-1:0] data_o
);

   slot_state_e         state_q, state_d;
   logic [BUS_BITS-1:0] data_q, data_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= SLOT_EMPTY;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
      end
   end

   // A load wins over a drain in the same cycle so back-to-back words keep valid high.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      if (load_i) begin
         state_d = SLOT_FULL;
         data_d  = data_i;
      end else if (state_q == SLOT_FULL && ready_i) begin
         state_d = SLOT_EMPTY;
      end
   end

   assign valid_o = (state_q == SLOT_FULL);
   assign data_o  = data_q;

endmodule

// File: rtl/demux2_stream.sv
// rtl/demux2_stream.sv - registered 1-to-2 stream demux; DEMUX2_COUNT_EN adds per-output drain counters
module demux2_stream
   import demux2_stream_pkg::*;
#(
   parameter int BUS_BITS = BUS_BITS_DEF
`ifdef DEMUX2_COUNT_EN
   ,
   parameter int CNT_BITS = CNT_BITS_DEF
`endif
) (
   input  logic                 clk,
   input  logic                 reset,
   demux2_stream_if.slave       bus
`ifdef DEMUX2_COUNT_EN
   ,
   output logic [CNT_BITS-1:0]  out1_count,
   output logic [CNT_BITS-1:0]  out2_count
`endif
);

   logic slot1_open, slot2_open;
   logic accept, load1, load2;
   logic drain1, drain2;

   // Readiness looks only at the selected slot, so a stalled destination never blocks the other.
   assign slot1_open   = !bus.out1_valid || bus.out1_ready;
   assign slot2_open   = !bus.out2_valid || bus.out2_ready;
   assign bus.in_ready = !reset && ((bus.sel == SEL_OUT2) ? slot2_open : slot1_open);

   assign accept = bus.in_valid && bus.in_ready;
   assign load1  = accept && (bus.sel == SEL_OUT1);
   assign load2  = accept && (bus.sel == SEL_OUT2);
   assign drain1 = bus.out1_valid && bus.out1_ready;
   assign drain2 = bus.out2_valid && bus.out2_ready;

   stream_slot #(.BUS_BITS(BUS_BITS)) u_slot1 (
      .clk     (clk),
      .reset   (reset),
      .load_i  (load1),
      .data_i  (bus.in_data),
      .ready_i (bus.out1_ready),
      .valid_o (bus.out1_valid),
      .data_o  (bus.out1_data)
   );

   stream_slot #(.BUS_BITS(BUS_BITS)) u_slot2 (
      .clk     (clk),
      .reset   (reset),
      .load_i  (load2),
      .data_i  (bus.in_data),
      .ready_i (bus.out2_ready),
      .valid_o (bus.out2_valid),
      .data_o  (bus.out2_data)
   );

`ifdef DEMUX2_COUNT_EN
   logic [CNT_BITS-1:0] cnt1_q, cnt1_d;
   logic [CNT_BITS-1:0] cnt2_q, cnt2_d;

   always_comb begin
      cnt1_d = cnt1_q;
      cnt2_d = cnt2_q;
      if (drain1) cnt1_d = cnt1_q + 1'b1;
      if (drain2) cnt2_d = cnt2_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt1_q <= '0;
         cnt2_q <= '0;
      end else begin
         cnt1_q <= cnt1_d;
         cnt2_q <= cnt2_d;
      end
   end

   assign out1_count = cnt1_q;
   assign out2_count = cnt2_q;
`else
   logic unused_drains;
   assign unused_drains = drain1 ^ drain2;
`endif

endmodule

// File: tb/tb_demux2_stream.sv
// tb/tb_demux2_stream.sv - directed bench for demux2_stream; counter checks run when DEMUX2_COUNT_EN is defined (CNT_BITS=4)
module tb_demux2_stream;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   demux2_stream_if #(.BUS_BITS(64)) bus ();

`ifdef DEMUX2_COUNT_EN
   logic [3:0] out1_count;
   logic [3:0] out2_count;
`endif

   demux2_stream #(
      .BUS_BITS(64)
`ifdef DEMUX2_COUNT_EN
      ,
      .CNT_BITS(4)
`endif
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
`ifdef DEMUX2_COUNT_EN
      ,
      .out1_count (out1_count),
      .out2_count (out2_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Upstream must hold in_data/sel while stalled.
   logic        stall_q;
   logic [63:0] held_data_q;
   logic        held_sel_q;
   initial stall_q = 1'b0;
   always @(posedge clk) begin
      if (stall_q && bus.in_valid && (bus.in_data !== held_data_q || bus.sel !== held_sel_q))
         $display("upstream hold violation at %0t", $time);
      stall_q     <= bus.in_valid && !bus.in_ready && !reset;
      held_data_q <= bus.in_data;
      held_sel_q  <= bus.sel;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset          = 1'b1;
      bus.in_valid   = 1'b1;
      bus.in_data    = 64'd5;
      bus.sel        = 1'b0;
      bus.out1_ready = 1'b0;
      bus.out2_ready = 1'b0;

      // reset hold with in_valid asserted
      tick();
      tick();
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_v1", bus.out1_valid, 0);
      chk("rst_v2", bus.out2_valid, 0);
      chk("rst_d1", bus.out1_data, 0);
      chk("rst_d2", bus.out2_data, 0);
`ifdef DEMUX2_COUNT_EN
      chk("rst_c1", out1_count, 0);
      chk("rst_c2", out2_count, 0);
`endif
      reset = 1'b0;
      bus.in_valid = 1'b0;
      tick();

      // basic route
      bus.out1_ready = 1'b1;
      bus.out2_ready = 1'b1;
      bus.in_data    = 64'd64;
      bus.sel        = 1'b0;
      bus.in_valid   = 1'b1;
      #1 chk("basic_in_ready", bus.in_ready, 1);
      tick();
      bus.in_data = 64'd45;
      bus.sel     = 1'b1;
      chk("basic_v1", bus.out1_valid, 1);
      chk("basic_d1", bus.out1_data, 64);
      chk("basic_v2_idle", bus.out2_valid, 0);
      tick();
      bus.in_valid = 1'b0;
      chk("basic_v2", bus.out2_valid, 1);
      chk("basic_d2", bus.out2_data, 45);
      chk("basic_v1_drained", bus.out1_valid, 0);
      tick();
      chk("basic_v2_drained", bus.out2_valid, 0);

      // backpressure on out1
      bus.out1_ready = 1'b0;
      bus.in_data    = 64'hAA;
      bus.sel        = 1'b0;
      bus.in_valid   = 1'b1;
      #1 chk("bp_first_ready", bus.in_ready, 1);
      tick();
      bus.in_data = 64'hBB;
      chk("bp_v1", bus.out1_valid, 1);
      chk("bp_d1", bus.out1_data, 64'hAA);
      #1 chk("bp_stall", bus.in_ready, 0);
      tick();
      chk("bp_hold_d1", bus.out1_data, 64'hAA);
      chk("bp_stall2", bus.in_ready, 0);
      bus.out1_ready = 1'b1;
      #1 chk("bp_release", bus.in_ready, 1);
      tick();
      bus.in_valid   = 1'b0;
      bus.out1_ready = 1'b0;
      chk("bp_b2b_v1", bus.out1_valid, 1);
      chk("bp_b2b_d1", bus.out1_data, 64'hBB);

      // independent stall: slot1 full and stalled, send to slot2
      bus.in_data    = 64'h55;
      bus.sel        = 1'b1;
      bus.in_valid   = 1'b1;
      bus.out2_ready = 1'b1;
      #1 chk("ind_in_ready", bus.in_ready, 1);
      tick();
      bus.in_valid = 1'b0;
      chk("ind_v2", bus.out2_valid, 1);
      chk("ind_d2", bus.out2_data, 64'h55);
      chk("ind_v1", bus.out1_valid, 1);
      chk("ind_d1", bus.out1_data, 64'hBB);
      bus.out1_ready = 1'b1;
      tick();
      chk("ind_v1_drained", bus.out1_valid, 0);
      chk("ind_v2_drained", bus.out2_valid, 0);
`ifdef DEMUX2_COUNT_EN
      chk("mid_c1", out1_count, 3);
      chk("mid_c2", out2_count, 2);
`endif

      // streaming 1..8, alternating destinations
      for (int i = 1; i <= 8; i++) begin
         bus.in_data  = 64'(i);
         bus.sel      = (i % 2 == 0);
         bus.in_valid = 1'b1;
         #1 chk($sformatf("stream_rdy_%0d", i), bus.in_ready, 1);
         tick();
         if (i % 2 == 1) begin
            chk($sformatf("stream_v1_%0d", i), bus.out1_valid, 1);
            chk($sformatf("stream_d1_%0d", i), bus.out1_data, 64'(i));
            chk($sformatf("stream_v2off_%0d", i), bus.out2_valid, 0);
         end else begin
            chk($sformatf("stream_v2_%0d", i), bus.out2_valid, 1);
            chk($sformatf("stream_d2_%0d", i), bus.out2_data, 64'(i));
            chk($sformatf("stream_v1off_%0d", i), bus.out1_valid, 0);
         end
      end
      bus.in_valid = 1'b0;
      tick();
      chk("stream_end_v1", bus.out1_valid, 0);
      chk("stream_end_v2", bus.out2_valid, 0);

      // reset mid-stream discards a held word
      bus.out2_ready = 1'b0;
      bus.in_data    = 64'h77;
      bus.sel        = 1'b1;
      bus.in_valid   = 1'b1;
      tick();
      chk("mrst_v2_held", bus.out2_valid, 1);
      reset = 1'b1;
      #1 chk("mrst_in_ready", bus.in_ready, 0);
      tick();
      chk("mrst_v2", bus.out2_valid, 0);
      chk("mrst_d2", bus.out2_data, 0);
      chk("mrst_v1", bus.out1_valid, 0);
`ifdef DEMUX2_COUNT_EN
      chk("mrst_c1", out1_count, 0);
      chk("mrst_c2", out2_count, 0);
`endif
      reset = 1'b0;

      // 17 words to out2; with a 4-bit counter this wraps to 1
      bus.out2_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         bus.in_data  = 64'(100 + i);
         bus.sel      = 1'b1;
         bus.in_valid = 1'b1;
         tick();
         chk($sformatf("wrap_d2_%0d", i), bus.out2_data, 64'(100 + i));
      end
      bus.in_valid = 1'b0;
      tick();
      chk("wrap_v2_end", bus.out2_valid, 0);
`ifdef DEMUX2_COUNT_EN
      chk("wrap_c2", out2_count, 1);
      chk("wrap_c1", out1_count, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
